// File: rtl/micro_hash_if.sv
// Block/result handshake bundle for micro_hash.
// The design side takes the slave modport; the block supplier takes master.
interface micro_hash_if;
    logic [15:0][7:0] block_in;
    logic             block_valid;
    logic [7:0]       target;
    logic             block_ready;
    logic             busy;
    logic [2:0][7:0]  hash_out;
    logic             hash_done;
    logic             hash_valid;

    modport slave (
        input  block_in, block_valid, target,
        output block_ready, busy, hash_out, hash_done, hash_valid
    );

    modport master (
        output block_in, block_valid, target,
        input  block_ready, busy, hash_out, hash_done, hash_valid
    );
endinterface

// File: rtl/micro_hash.sv
// 32-round byte-wide hash over a 16-byte block, one round per clock.
// Message words are expanded on the fly from a sliding 16-byte window.
module micro_hash (
    input  logic        clk,
    input  logic        reset,
    micro_hash_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       round_q, round_d;
    logic [7:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic [7:0]       target_q, target_d;
    logic [15:0][7:0] window_q, window_d;
    logic [2:0][7:0]  hash_q, hash_d;
    logic             hashValid_q, hashValid_d;
    logic             hashDone_q, hashDone_d;

    logic             accept;
    logic [7:0]       mixX, roundK, nextW;
    logic [7:0]       h0, h1, h2;

    assign accept = (state_q == IDLE) && bus.block_valid;

    // window_q[0] always holds W[r]; the word entering at the top is W[r+16]
    assign nextW  = (window_q[13] | window_q[7]) ^ window_q[2];
    assign mixX   = (round_q <= 5'd16) ? (b_q ^ c_q) : (a_q ^ b_q ^ c_q);
    assign roundK = (round_q <= 5'd16) ? 8'h99 : 8'hA1;
    assign h0     = 8'h01 + a_q;
    assign h1     = 8'h89 + b_q;
    assign h2     = 8'hFE + c_q;

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        target_d    = target_q;
        window_d    = window_q;
        hash_d      = hash_q;
        hashValid_d = hashValid_q;
        hashDone_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    window_d = bus.block_in;
                    target_d = bus.target;
                    a_d      = 8'h01;
                    b_d      = 8'h89;
                    c_d      = 8'hFE;
                    round_d  = 5'd0;
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                a_d      = b_q ^ c_q;
                b_d      = {c_q[3:0], 4'h0};
                c_d      = mixX + roundK + window_q[0];
                window_d = {nextW, window_q[15:1]};
                round_d  = round_q + 5'd1;
                if (round_q == 5'd31) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                hash_d      = {h2, h1, h0};
                hashValid_d = (h0 < target_q) && (h1 < target_q);
                hashDone_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= 5'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            c_q         <= 8'h00;
            target_q    <= 8'h00;
            window_q    <= '0;
            hash_q      <= '0;
            hashValid_q <= 1'b0;
            hashDone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            target_q    <= target_d;
            window_q    <= window_d;
            hash_q      <= hash_d;
            hashValid_q <= hashValid_d;
            hashDone_q  <= hashDone_d;
        end
    end

    assign bus.block_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.hash_out    = hash_q;
    assign bus.hash_done   = hashDone_q;
    assign bus.hash_valid  = hashValid_q;
endmodule

// File: tb/tb_micro_hash.sv
// Self-checking bench for micro_hash: directed latency/reset/abort scenarios
// plus a randomized regression against a plain-arithmetic reference hash.
module tb_micro_hash;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    micro_hash_if hif();

    micro_hash dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] model_hash(input logic [15:0][7:0] blk);
        logic [7:0] w [32];
        logic [7:0] a, b, c, x, k, na, nb, nc;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 32; i++) w[i] = (w[i-3] | w[i-9]) ^ w[i-14];
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            x  = (i <= 16) ? (b ^ c) : (a ^ b ^ c);
            k  = (i <= 16) ? 8'h99 : 8'hA1;
            na = b ^ c;
            nb = 8'((c * 16) % 256);
            nc = 8'((int'(x) + int'(k) + int'(w[i])) % 256);
            a = na; b = nb; c = nc;
        end
        return {8'((254 + int'(c)) % 256), 8'((137 + int'(b)) % 256), 8'((1 + int'(a)) % 256)};
    endfunction

    function automatic logic model_valid(input logic [23:0] h, input logic [7:0] tgt);
        return (h[7:0] < tgt) && (h[15:8] < tgt);
    endfunction

    function automatic logic [15:0][7:0] rand_block();
        logic [15:0][7:0] blk;
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
        return blk;
    endfunction

    // Leaves the caller at the falling edge right after the accepting edge E0.
    task automatic send_block(input logic [15:0][7:0] blk, input logic [7:0] tgt);
        @(negedge clk);
        hif.block_in    = blk;
        hif.target      = tgt;
        hif.block_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hif.block_valid = 1'b0;
        hif.block_in    = rand_block();
        hif.target      = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(output int doneCycle, output int busyCycles);
        doneCycle  = -1;
        busyCycles = 0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (hif.busy) busyCycles++;
            if (hif.hash_done) begin
                doneCycle = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hif.block_valid = 1'b0;
        hif.block_in    = '0;
        hif.target      = 8'h00;
        reset = 1'b1;
        #1;
        checks++;
        if (hif.hash_out !== 24'h0 || hif.hash_valid !== 1'b0 || hif.hash_done !== 1'b0 ||
            hif.busy !== 1'b0 || hif.block_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state got out=%h valid=%b done=%b busy=%b ready=%b want 000000 0 0 0 1",
                     hif.hash_out, hif.hash_valid, hif.hash_done, hif.busy, hif.block_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency();
        logic [15:0][7:0] blk;
        logic [23:0] exp;
        int doneCycle, busyCycles;
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        exp = model_hash(blk);
        send_block(blk, 8'hFF);
        wait_done(doneCycle, busyCycles);
        checks++;
        if (doneCycle !== 33) begin
            failures++;
            $display("[TB] FAIL latency_done_cycle got %0d want 33", doneCycle);
        end
        checks++;
        if (busyCycles !== 33) begin
            failures++;
            $display("[TB] FAIL latency_busy_cycles got %0d want 33", busyCycles);
        end
        checks++;
        if (hif.hash_out !== exp || hif.hash_valid !== model_valid(exp, 8'hFF)) begin
            failures++;
            $display("[TB] FAIL latency_hash got %h/%b want %h/%b",
                     hif.hash_out, hif.hash_valid, exp, model_valid(exp, 8'hFF));
        end
        checks++;
        if (hif.block_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_ready got %b want 1", hif.block_ready);
        end
        @(negedge clk);
        checks++;
        if (hif.hash_done !== 1'b0 || hif.hash_out !== exp) begin
            failures++;
            $display("[TB] FAIL latency_pulse_hold got done=%b out=%h want 0 %h",
                     hif.hash_done, hif.hash_out, exp);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (hif.hash_out !== 24'h0 || hif.hash_valid !== 1'b0 || hif.busy !== 1'b0 ||
            hif.block_ready !== 1'b1 || hif.hash_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got out=%h valid=%b busy=%b ready=%b done=%b",
                     hif.hash_out, hif.hash_valid, hif.busy, hif.block_ready, hif.hash_done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_target_sweep();
        logic [15:0][7:0] blk;
        logic [23:0] exp;
        int doneCycle, busyCycles;
        for (int i = 0; i < 16; i++) blk[i] = 8'(i);
        exp = model_hash(blk);
        send_block(blk, 8'h00);
        wait_done(doneCycle, busyCycles);
        checks++;
        if (doneCycle < 0 || hif.hash_valid !== 1'b0 || hif.hash_out !== exp) begin
            failures++;
            $display("[TB] FAIL target_zero got done=%0d valid=%b out=%h want valid=0 out=%h",
                     doneCycle, hif.hash_valid, hif.hash_out, exp);
        end
        send_block(blk, 8'hFF);
        wait_done(doneCycle, busyCycles);
        checks++;
        if (doneCycle < 0 || hif.hash_valid !== model_valid(exp, 8'hFF)) begin
            failures++;
            $display("[TB] FAIL target_ff got done=%0d valid=%b want %b",
                     doneCycle, hif.hash_valid, model_valid(exp, 8'hFF));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0][7:0] blkA, blkB;
        logic [7:0] tgtA, tgtB;
        logic [23:0] expA, expB;
        int firstDone, secondDone, readyErrs;
        blkA = rand_block();
        blkB = rand_block();
        tgtA = 8'($urandom_range(1, 255));
        tgtB = 8'($urandom_range(1, 255));
        expA = model_hash(blkA);
        expB = model_hash(blkB);
        firstDone  = -1;
        secondDone = -1;
        readyErrs  = 0;
        send_block(blkA, tgtA);
        hif.block_valid = 1'b1;
        for (int k = 0; k < 90; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 33 && hif.block_ready !== 1'b0) readyErrs++;
            if (hif.hash_done && firstDone < 0) begin
                firstDone = k;
                checks++;
                if (hif.hash_out !== expA || hif.hash_valid !== model_valid(expA, tgtA)) begin
                    failures++;
                    $display("[TB] FAIL b2b_first_hash got %h/%b want %h/%b",
                             hif.hash_out, hif.hash_valid, expA, model_valid(expA, tgtA));
                end
            end else if (hif.hash_done && firstDone >= 0) begin
                secondDone = k;
                break;
            end
            if (firstDone < 0) begin
                hif.block_in = rand_block();
                hif.target   = 8'($urandom_range(0, 255));
            end else if (k == firstDone) begin
                hif.block_in = blkB;
                hif.target   = tgtB;
            end else begin
                hif.block_valid = 1'b0;
                hif.block_in    = rand_block();
                hif.target      = 8'($urandom_range(0, 255));
            end
        end
        hif.block_valid = 1'b0;
        checks++;
        if (readyErrs != 0) begin
            failures++;
            $display("[TB] FAIL b2b_ready_low got %0d cycles with ready=1 want 0", readyErrs);
        end
        checks++;
        if (firstDone != 33 || secondDone != 67) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got done at %0d,%0d want 33,67", firstDone, secondDone);
        end
        checks++;
        if (hif.hash_out !== expB || hif.hash_valid !== model_valid(expB, tgtB)) begin
            failures++;
            $display("[TB] FAIL b2b_second_hash got %h/%b want %h/%b",
                     hif.hash_out, hif.hash_valid, expB, model_valid(expB, tgtB));
        end
    endtask

    task automatic test_abort();
        logic [15:0][7:0] blk;
        logic [23:0] exp;
        int doneCycle, busyCycles, spurious;
        send_block(rand_block(), 8'hFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        hif.block_valid = 1'b1;
        hif.block_in    = rand_block();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hif.block_valid = 1'b0;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hif.hash_done !== 1'b0 || hif.busy !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0 || hif.hash_out !== 24'h0 || hif.hash_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort got %0d done/busy cycles out=%h valid=%b want 0 000000 0",
                     spurious, hif.hash_out, hif.hash_valid);
        end
        for (int i = 0; i < 16; i++) blk[i] = 8'hAA;
        exp = model_hash(blk);
        send_block(blk, 8'h80);
        wait_done(doneCycle, busyCycles);
        checks++;
        if (doneCycle != 33 || hif.hash_out !== exp || hif.hash_valid !== model_valid(exp, 8'h80)) begin
            failures++;
            $display("[TB] FAIL abort_restart got done=%0d %h/%b want 33 %h/%b",
                     doneCycle, hif.hash_out, hif.hash_valid, exp, model_valid(exp, 8'h80));
        end
    endtask

    task automatic test_random();
        logic [15:0][7:0] blk;
        logic [7:0] tgt;
        logic [23:0] exp;
        int doneCycle, busyCycles;
        for (int n = 0; n < 1000; n++) begin
            blk = rand_block();
            case ($urandom_range(0, 7))
                0:       tgt = 8'h00;
                1:       tgt = 8'hFF;
                default: tgt = 8'($urandom_range(0, 255));
            endcase
            exp = model_hash(blk);
            send_block(blk, tgt);
            wait_done(doneCycle, busyCycles);
            checks++;
            if (doneCycle != 33 || hif.hash_out !== exp) begin
                failures++;
                $display("[TB] FAIL random_hash[%0d] got done=%0d out=%h want 33 %h",
                         n, doneCycle, hif.hash_out, exp);
            end
            checks++;
            if (hif.hash_valid !== model_valid(exp, tgt)) begin
                failures++;
                $display("[TB] FAIL random_valid[%0d] got %b want %b tgt=%h",
                         n, hif.hash_valid, model_valid(exp, tgt), tgt);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        test_reset();
        test_latency();
        test_async_reset();
        test_target_sweep();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/micro_hash.md
MICRO_HASH -- requirements
Module: micro_hash

Interface
REQ-001 The block SHALL provide the following ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- block_in  in  [15:0][7:0]  16-byte block from concatenator_in; byte k = block_in[k]; byte 0 = W[0].
- block_valid  in  1  block_in is valid this cycle.
- target  in  8  difficulty threshold, sampled at accept.
- block_ready  out  1  block can accept a new block.
- busy  out  1  hash in progress.
- hash_out  out  [2:0][7:0]  final {H2,H1,H0}, with H0 in byte 0.
- hash_done  out  1  one-cycle pulse when hash_out updates.
- hash_valid  out  1  the hash meets target; held with hash_out.

REQ-002 The block SHALL have no parameters; all widths SHALL be fixed as listed.

Function
REQ-003 Accept SHALL occur on a rising edge where block_valid=1 and block_ready=1.
- On accept, the block SHALL capture all 16 bytes and target.
- On accept, the block SHALL load a=0x01, b=0x89, c=0xFE, round counter r=0.
REQ-004 FSM states SHALL be IDLE, ROUND, FINAL.
- IDLE->ROUND on accept.
- ROUND->ROUND while r<31.
- ROUND->FINAL after round 31.
- FINAL->IDLE unconditionally.
REQ-005 block_ready SHALL be 1 only in IDLE.
REQ-006 busy SHALL be 1 in ROUND and FINAL.
REQ-007 block_valid outside IDLE SHALL be ignored; the block SHALL not queue it.
REQ-008 Message schedule: W[i]=block byte i for i<16.
- For 16<=i<=31: W[i] = (W[i-3] | W[i-9]) ^ W[i-14], 8-bit.
- W SHALL be generated on the fly from a 16-entry byte shift window, one W per cycle.
REQ-009 Round i (one per ROUND cycle):
- For i<=16: k=0x99 and x=b^c.
- For i>16: k=0xA1 and x=a^b^c.
- Then a'=b^c, b'=(c<<4) mod 256, c'=(x+k+W[i]) mod 256.
- All updates SHALL be simultaneous.
REQ-010 FINAL SHALL compute H0=(0x01+a) mod 256, H1=(0x89+b) mod 256, H2=(0xFE+c) mod 256.
- It SHALL register these into hash_out.
- It SHALL set hash_valid=(H0<target)&&(H1<target), unsigned, using the target captured at accept.
- It SHALL pulse hash_done for exactly one cycle.
REQ-011 Latency SHALL be fixed:
- Accept at edge E0, rounds 0..31 at edges E1..E32, FINAL at E33.
- hash_done=1 during the cycle after E33.
- block_ready=1 again after E33.
- The next accept SHALL occur at earliest at E34, giving back-to-back throughput of one block per 34 cycles.
REQ-012 hash_out and hash_valid SHALL hold until the next FINAL or reset; new inputs SHALL not disturb them.
REQ-013 Changes on block_in or target after accept SHALL have no effect on the hash in progress.
REQ-014 All additions SHALL wrap modulo 256; the block SHALL not produce any carry or overflow flag.
REQ-015 With target=0x00, hash_valid SHALL always be 0.

Reset
REQ-016 reset=1 SHALL immediately force the following, independent of clk:
- State=IDLE, a=b=c=0, r=0, W window=0.
- hash_out=0, hash_valid=0, hash_done=0, busy=0, block_ready=1.
REQ-017 Reset during ROUND or FINAL SHALL abort the hash with no hash_done pulse.
- After reset deasserts, the first accept SHALL restart cleanly from REQ-003.
REQ-018 block_valid while reset=1 SHALL be ignored.

Verification
REQ-019 Reset: assert reset mid-cycle with no clk edge -> all outputs reach the REQ-016 values immediately.
REQ-020 Latency: block bytes 0x00..0x0F, target=0xFF, accept at E0 -> single hash_done pulse after E33.
- hash_out SHALL equal the golden model output.
- busy=1 for exactly 33 cycles.
REQ-021 Target sweep: same block with target=0x00 -> hash_valid=0.
- With target=0xFF, hash_valid=1 iff the model gives H0<0xFF and H1<0xFF.
REQ-022 Busy rejection: hold block_valid=1 with changing block_in through rounds -> block_ready=0 and the result is unchanged.
- The next block SHALL be accepted at E34, and the second hash_done SHALL follow 34 cycles after the first.
REQ-023 Abort: assert reset at round 10 -> no hash_done and hash_out=0.
- A new all-0xAA block after release SHALL match the model.
REQ-024 Random regression: 1000 random blocks and targets -> hash_out and hash_valid SHALL match the model bit-exactly each time.
